// File: rtl/wbm_pkg.sv
// Shared types and response status codes for the Wishbone command master.
package wbm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUS     = 2'd1,
        RELEASE = 2'd2,
        RESP    = 2'd3
    } wbm_state_e;

    localparam logic [1:0] WBM_OK      = 2'b00;
    localparam logic [1:0] WBM_ERR     = 2'b01;
    localparam logic [1:0] WBM_TIMEOUT = 2'b10;
    localparam logic [1:0] WBM_STUCK   = 2'b11;

endpackage

// File: rtl/wbm_timeout_ctr.sv
// Cycle counter bounding time spent in BUS and RELEASE; expired at TIMEOUT_CYCLES-1.
module wbm_timeout_ctr
    import wbm_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/wbm_cmd_master.sv
// Single-outstanding Wishbone master: valid/ready command in, classic single cycle on
// the bus, waits for ack/err release, then presents a registered response.
module wbm_cmd_master
    import wbm_pkg::*;
#(
    parameter  int unsigned BUS_DATA_WIDTH = 32,
    parameter  int unsigned BUS_ADDR_WIDTH = 8,
    parameter  int unsigned TIMEOUT_CYCLES = 255,
    localparam int unsigned BYTE_ENABLES   = BUS_DATA_WIDTH / 8
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic                      cmd_we_i,
    input  logic [BUS_ADDR_WIDTH-1:0] cmd_adr_i,
    input  logic [BUS_DATA_WIDTH-1:0] cmd_dat_i,
    input  logic [BYTE_ENABLES-1:0]   cmd_sel_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [BUS_DATA_WIDTH-1:0] rsp_dat_o,
    output logic [1:0]                rsp_status_o,
    output logic                      wbm_cyc_o,
    output logic                      wbm_stb_o,
    output logic                      wbm_we_o,
    output logic [BYTE_ENABLES-1:0]   wbm_sel_o,
    output logic [BUS_ADDR_WIDTH-1:0] wbm_adr_o,
    output logic [BUS_DATA_WIDTH-1:0] wbm_dat_o,
    input  logic [BUS_DATA_WIDTH-1:0] wbm_dat_i,
    input  logic                      wbm_ack_i,
    input  logic                      wbm_err_i
);

    wbm_state_e                state_q;
    logic                      cmd_ready_q;
    logic                      rsp_valid_q;
    logic [BUS_DATA_WIDTH-1:0] rsp_dat_q;
    logic [1:0]                rsp_status_q;
    logic                      cyc_q;
    logic                      stb_q;
    logic                      we_q;
    logic [BYTE_ENABLES-1:0]   sel_q;
    logic [BUS_ADDR_WIDTH-1:0] adr_q;
    logic [BUS_DATA_WIDTH-1:0] dat_q;

    logic expired;
    logic bus_done;
    logic cnt_clr;
    logic cnt_en;

    assign bus_done = wbm_err_i | wbm_ack_i | expired;
    // Counter runs only while waiting in BUS or RELEASE; any BUS exit restarts it for RELEASE.
    assign cnt_clr  = (state_q == IDLE) || (state_q == RESP) || ((state_q == BUS) && bus_done);
    assign cnt_en   = !cnt_clr;

    wbm_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk_i    (wb_clk_i),
        .rst_i    (wb_rst_i),
        .clr_i    (cnt_clr),
        .en_i     (cnt_en),
        .expired_o(expired)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q      <= IDLE;
            cmd_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_dat_q    <= '0;
            rsp_status_q <= WBM_OK;
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            we_q         <= 1'b0;
            sel_q        <= '0;
            adr_q        <= '0;
            dat_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        we_q        <= cmd_we_i;
                        adr_q       <= cmd_adr_i;
                        dat_q       <= cmd_dat_i;
                        sel_q       <= cmd_sel_i;
                        cyc_q       <= 1'b1;
                        stb_q       <= 1'b1;
                        cmd_ready_q <= 1'b0;
                        state_q     <= BUS;
                    end
                end
                BUS: begin
                    if (bus_done) begin
                        // err outranks ack when both arrive together
                        if (wbm_err_i) begin
                            rsp_status_q <= WBM_ERR;
                            rsp_dat_q    <= '0;
                        end else if (wbm_ack_i) begin
                            rsp_status_q <= WBM_OK;
                            rsp_dat_q    <= we_q ? '0 : wbm_dat_i;
                        end else begin
                            rsp_status_q <= WBM_TIMEOUT;
                            rsp_dat_q    <= '0;
                        end
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        we_q    <= 1'b0;
                        sel_q   <= '0;
                        state_q <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!wbm_ack_i && !wbm_err_i) begin
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else if (expired) begin
                        if (rsp_status_q == WBM_OK) begin
                            rsp_status_q <= WBM_STUCK;
                        end
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready_o  = cmd_ready_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_dat_o    = rsp_dat_q;
    assign rsp_status_o = rsp_status_q;
    assign wbm_cyc_o    = cyc_q;
    assign wbm_stb_o    = stb_q;
    assign wbm_we_o     = we_q;
    assign wbm_sel_o    = sel_q;
    assign wbm_adr_o    = adr_q;
    assign wbm_dat_o    = dat_q;

endmodule

// File: tb/tb_wbm_cmd_master.sv
// Directed bench for wbm_cmd_master with a mode-switchable slave and a transaction-level model.
module tb_wbm_cmd_master;

    localparam int unsigned TO = 8;
    localparam logic [1:0] M_NORMAL = 2'd0;
    localparam logic [1:0] M_NOACK  = 2'd1;
    localparam logic [1:0] M_ACKERR = 2'd2;
    localparam logic [1:0] M_STUCK  = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [7:0]  cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic [1:0]  rsp_status;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [7:0]  adr;
    logic [31:0] wdat;
    logic [31:0] rdat;
    logic        s_ack = 1'b0;
    logic        s_err = 1'b0;
    logic [1:0]  mode = M_NORMAL;

    logic [31:0] smem [256];
    logic [31:0] rmem [256];

    int n_cmp = 0;
    int n_err = 0;
    int stb_cnt = 0;
    bit in_flight = 0;
    logic        exp_we;
    logic [7:0]  exp_adr;
    logic [31:0] exp_wdat;
    logic [3:0]  exp_sel;
    logic [1:0]  exp_st;
    logic [31:0] exp_rdat;

    always #5 clk = ~clk;

    wbm_cmd_master #(
        .BUS_DATA_WIDTH(32),
        .BUS_ADDR_WIDTH(8),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_we_i    (cmd_we),
        .cmd_adr_i   (cmd_adr),
        .cmd_dat_i   (cmd_dat),
        .cmd_sel_i   (cmd_sel),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_dat_o   (rsp_dat),
        .rsp_status_o(rsp_status),
        .wbm_cyc_o   (cyc),
        .wbm_stb_o   (stb),
        .wbm_we_o    (we),
        .wbm_sel_o   (sel),
        .wbm_adr_o   (adr),
        .wbm_dat_o   (wdat),
        .wbm_dat_i   (rdat),
        .wbm_ack_i   (s_ack),
        .wbm_err_i   (s_err)
    );

    // Slave: registered ack one cycle after stb, held while stb; other modes misbehave on purpose.
    assign rdat = (mode == M_ACKERR) ? 32'h0000_1234 : smem[adr];

    always @(posedge clk) begin
        case (mode)
            M_NORMAL: begin s_ack <= cyc & stb; s_err <= 1'b0; end
            M_NOACK:  begin s_ack <= 1'b0;      s_err <= 1'b0; end
            M_ACKERR: begin s_ack <= cyc & stb; s_err <= cyc & stb; end
            default:  begin s_ack <= s_ack | (cyc & stb); s_err <= 1'b0; end
        endcase
        if (cyc && stb && we && s_ack && !s_err) begin
            for (int b = 0; b < 4; b++) begin
                if (sel[b]) smem[adr][8*b +: 8] <= wdat[8*b +: 8];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level prediction: outcome depends only on the slave's behaviour class.
    task automatic predict(input logic [1:0] m, input logic w, input logic [7:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        exp_we = w; exp_adr = a; exp_wdat = d; exp_sel = s;
        case (m)
            M_NORMAL: begin exp_st = 2'b00; exp_rdat = w ? 32'h0 : rmem[a]; end
            M_NOACK:  begin exp_st = 2'b10; exp_rdat = 32'h0; end
            M_ACKERR: begin exp_st = 2'b01; exp_rdat = 32'h0; end
            default:  begin exp_st = 2'b11; exp_rdat = w ? 32'h0 : rmem[a]; end
        endcase
        if (w && (m == M_NORMAL || m == M_STUCK)) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) rmem[a][8*b +: 8] = d[8*b +: 8];
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("cmd_ready", {31'b0, cmd_ready}, {31'b0, !in_flight});
            if (stb) begin
                stb_cnt++;
                chk("cyc_with_stb", {31'b0, cyc}, 32'h1);
                chk("wbm_we", {31'b0, we}, {31'b0, exp_we});
                chk("wbm_adr", {24'b0, adr}, {24'b0, exp_adr});
                chk("wbm_dat", wdat, exp_wdat);
                chk("wbm_sel", {28'b0, sel}, {28'b0, exp_sel});
            end
            if (rsp_valid) begin
                chk("rsp_in_flight", {31'b0, in_flight}, 32'h1);
                chk("rsp_dat", rsp_dat, exp_rdat);
                chk("rsp_status", {30'b0, rsp_status}, {30'b0, exp_st});
            end
        end
    end

    task automatic run_cmd(input string nm, input logic [1:0] m, input logic w,
                           input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] lit_st, input logic [31:0] lit_dat,
                           input int lit_lat, input int lit_stb, input int hold);
        int n;
        mode = m;
        predict(m, w, a, d, s);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = w; cmd_adr = a; cmd_dat = d; cmd_sel = s;
        n = 0;
        while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk);
        in_flight = 1;
        stb_cnt = 0;
        #1 cmd_valid = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!rsp_valid && n < 50);
        chk({nm, "_latency"}, n, lit_lat);
        repeat (hold) @(negedge clk);
        @(negedge clk);
        chk({nm, "_dat"}, rsp_dat, lit_dat);
        chk({nm, "_status"}, {30'b0, rsp_status}, {30'b0, lit_st});
        rsp_ready = 1'b1;
        @(posedge clk);
        in_flight = 0;
        #1 rsp_ready = 1'b0;
        chk({nm, "_stb_cycles"}, stb_cnt, lit_stb);
        mode = M_NORMAL;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) begin smem[i] = '0; rmem[i] = '0; end
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'h1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("rst_bus_ctl", {29'b0, cyc, stb, we}, 32'h0);
        chk("rst_sel_adr", {20'b0, sel, adr}, 32'h0);
        chk("rst_wdat", wdat, 32'h0);
        chk("rst_rsp", {rsp_dat[29:0], rsp_status} | rsp_dat, 32'h0);
        #2 rst = 1'b0;

        run_cmd("wr_deadbeef", M_NORMAL, 1'b1, 8'h00, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h0, 4, 2, 0);
        run_cmd("rd_deadbeef", M_NORMAL, 1'b0, 8'h00, 32'h0, 4'hF, 2'b00, 32'hDEAD_BEEF, 4, 2, 0);
        run_cmd("wr_partial", M_NORMAL, 1'b1, 8'h10, 32'h1122_3344, 4'b0101, 2'b00, 32'h0, 4, 2, 0);
        run_cmd("rd_partial", M_NORMAL, 1'b0, 8'h10, 32'h0, 4'hF, 2'b00, 32'h0022_0044, 4, 2, 0);
        run_cmd("timeout", M_NOACK, 1'b0, 8'h33, 32'h0, 4'hF, 2'b10, 32'h0, TO + 1, TO, 0);
        run_cmd("ack_err", M_ACKERR, 1'b0, 8'h00, 32'h0, 4'hF, 2'b01, 32'h0, 4, 2, 0);
        run_cmd("stuck", M_STUCK, 1'b0, 8'h00, 32'h0, 4'hF, 2'b11, 32'hDEAD_BEEF, TO + 2, 2, 0);
        run_cmd("wr_hold", M_NORMAL, 1'b1, 8'hFF, 32'hA5A5_5A5A, 4'hF, 2'b00, 32'h0, 4, 2, 5);
        run_cmd("rd_hold", M_NORMAL, 1'b0, 8'hFF, 32'h0, 4'hF, 2'b00, 32'hA5A5_5A5A, 4, 2, 5);

        // Reset asserted between edges while the master is strobing a silent slave.
        mode = M_NOACK;
        predict(M_NOACK, 1'b0, 8'h44, 32'h0, 4'hF);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 8'h44; cmd_sel = 4'hF;
        @(posedge clk);
        in_flight = 1;
        #1 cmd_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 chk("pre_rst_stb", {30'b0, cyc, stb}, 32'h3);
        #2 rst = 1'b1;
        in_flight = 0;
        #1;
        chk("async_rst_bus", {30'b0, cyc, stb}, 32'h0);
        chk("async_rst_ready", {31'b0, cmd_ready}, 32'h1);
        chk("async_rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        @(negedge clk);
        #2 rst = 1'b0;
        mode = M_NORMAL;
        repeat (2) @(negedge clk);
        run_cmd("rd_after_rst", M_NORMAL, 1'b0, 8'h00, 32'h0, 4'hF, 2'b00, 32'hDEAD_BEEF, 4, 2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
